cm0_dbg_ap: RTL and testbench
=============================

CM0_DBG_AP -- requirements
Module: cm0_dbg_ap

Interface
REQ-001 SHALL have parameter DBG, default 1: 1 = block present; 0 = all outputs tied 0 except ap_ack_o, which pulses one cycle after each request.
REQ-002 SHALL have parameter TAR_WRAP_BITS, default 10: TAR auto-increment wraps within a 2^TAR_WRAP_BITS-byte region.
REQ-003 dclk  input  1  debug clock; one clock only, all state on rising edge.
REQ-004 dbg_reset  input  1  debug reset; synchronous, active-high.
REQ-005 ap_req_i  input  1  DP-side register access request; held until ap_ack_o.
REQ-006 ap_write_i  input  1  request is a write.
REQ-007 ap_addr_i  input  3  AP register word select [4:2]: 0 CSW, 1 TAR, 3 DRW, 4-7 BD0-BD3.
REQ-008 ap_wdata_i  input  32  request write data.
REQ-009 ap_ack_o  output  1  one-cycle completion pulse.
REQ-010 ap_rdata_o  output  32  read data, valid with ap_ack_o.
REQ-011 ap_err_o  output  1  error flag, valid with ap_ack_o.
REQ-012 slv_trans_o  output  2  SLV transaction, AHB HTRANS encoding: 2'b00 IDLE, 2'b10 NONSEQ.
REQ-013 slv_addr_o  output  32; slv_size_o  output  2; slv_write_o  output  1; slv_wdata_o  output  32: SLV address-phase and data-phase controls.
REQ-014 slv_rdata_i  input  32; slv_ready_i  input  1; slv_resp_i  input  1: SLV read data, ready, error response.

Function
REQ-015 CSW SHALL hold SIZE[1:0] (0 byte, 1 half, 2 word, 3 reserved), ADDRINC[5:4] (00 off, 01 single, 1x reserved = off), ERR[6] sticky (write 1 clears), and BUSY[7] read-only; all other bits read 0.
REQ-016 CSW/TAR accesses SHALL ack on the cycle after ap_req_i is sampled in IDLE, with no SLV transfer.
REQ-017 FSM states: IDLE, ADDR, DATA, RESP. A DRW/BD request in IDLE moves the FSM to ADDR.
REQ-018 In ADDR, slv_trans_o SHALL be NONSEQ with addr, size, and write stable. The FSM moves to DATA on the first cycle slv_ready_i=1; otherwise it stays in ADDR.
REQ-019 In DATA, slv_trans_o SHALL be IDLE and slv_wdata_o SHALL carry the DRW write data. On slv_ready_i=1, the block SHALL capture slv_rdata_i and slv_resp_i, then move to RESP.
REQ-020 RESP SHALL pulse ap_ack_o for one cycle, set ap_err_o and CSW.ERR if slv_resp_i was captured as 1, and return to IDLE. The minimum DRW latency is 3 cycles from request to ack.
REQ-021 DRW address = TAR. BDn address = {TAR[31:4], n, 2'b00}, and BDn accesses always use word size.
REQ-022 After a DRW transfer that completes with no error and ADDRINC=01, TAR[TAR_WRAP_BITS-1:0] SHALL advance by 1, 2, or 4 bytes per SIZE, wrapping modulo 2^TAR_WRAP_BITS. Upper TAR bits are unchanged.
REQ-023 An errored transfer SHALL leave TAR unchanged. BD accesses SHALL never increment TAR.
REQ-024 A DRW/BD access with SIZE=3 SHALL ack with ap_err_o=1 after one cycle, set ERR, and issue no SLV transfer.
REQ-025 Requests are accepted only in IDLE; one transfer is outstanding at most. BUSY reads 1 in ADDR, DATA, and RESP.
REQ-026 Register address 2 SHALL read 0 and ignore writes, acking after one cycle.

Reset
REQ-027 On dbg_reset, the block SHALL clear CSW to 0x00000002 (word size, ADDRINC off, ERR 0) and TAR to 0, and set FSM to IDLE.
REQ-028 During and after reset, the block SHALL drive slv_trans_o=IDLE, ap_ack_o=0, ap_err_o=0, and all other outputs 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no ack, and slv_trans_o SHALL be IDLE on the next cycle.

Configuration
REQ-030 Macro CM0_DBG_AP_BD_EN SHALL control the banked data registers BD0-BD3. Defined: BD0-BD3 are implemented per REQ-021. Undefined: ap_addr_i 4-7 SHALL read 0, ignore writes, ack after one cycle, and issue no SLV transfer.

Structure
REQ-031 Package cm0_dbg_ap_pkg SHALL hold the register selects, CSW field positions and reset value, SIZE codes, HTRANS codes, and FSM state encoding.
REQ-032 Sub-module cm0_dbg_ap_tar SHALL hold the TAR register and its increment/wrap logic.

Verification
REQ-033 Reset -> read CSW returns 0x00000002, read TAR returns 0, and slv_trans_o=00 throughout.
REQ-034 Write TAR=0x20000000, then write DRW=0xDEADBEEF with slv_ready_i=1 -> one NONSEQ cycle with addr 0x20000000, wdata 0xDEADBEEF in the data phase, and ack 3 cycles after the request.
REQ-035 CSW=0x12 (word, inc), TAR=0x200003FC, read DRW twice -> addresses 0x200003FC then 0x20000000 (wrap), and TAR reads 0x20000000 then 0x20000004.
REQ-036 slv_ready_i low for 2 cycles in ADDR and 3 in DATA, with slv_resp_i=1 -> address held, ap_err_o=1, CSW.ERR=1, and TAR unchanged; writing CSW with bit6=1 clears ERR.
REQ-037 With CM0_DBG_AP_BD_EN: TAR=0x40001238, read BD2 -> addr 0x40001238, size word, TAR unchanged. Without the macro: read BD2 -> 0 after one cycle and no NONSEQ.
REQ-038 Set SIZE=3 and access DRW -> ap_err_o=1 one cycle later with no NONSEQ. Separately, assert dbg_reset while in DATA -> no ack, slv_trans_o=00, and CSW back to 0x00000002.

Source files
------------

// File: rtl/cm0_dbg_ap_pkg.sv
// Shared definitions for the debug access port: register selects, CSW layout,
// transfer size codes, HTRANS codes and the transfer FSM encoding.
package cm0_dbg_ap_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] REG_CSW = 3'd0;
    localparam logic [2:0] REG_TAR = 3'd1;
    localparam logic [2:0] REG_RSV = 3'd2;
    localparam logic [2:0] REG_DRW = 3'd3;

    localparam int unsigned CSW_SIZE_LSB = 0;
    localparam int unsigned CSW_INC_LSB  = 4;
    localparam int unsigned CSW_ERR_BIT  = 6;
    localparam int unsigned CSW_BUSY_BIT = 7;
    localparam logic [DATA_W-1:0] CSW_RESET = 32'h0000_0002;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSV  = 2'd3;

    localparam logic [1:0] INC_SINGLE = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/cm0_dbg_ap_tar.sv
// Transfer address register with size-based auto-increment that wraps inside
// a 2^TAR_WRAP_BITS-byte region; bits above the region are never touched.
module cm0_dbg_ap_tar
    import cm0_dbg_ap_pkg::*;
#(
    parameter int unsigned TAR_WRAP_BITS = 10
) (
    input  logic              dclk,
    input  logic              dbg_reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inc_en,
    input  logic [1:0]        inc_size,
    output logic [DATA_W-1:0] tar_o
);

    localparam logic [DATA_W-1:0] WRAP_MASK = (TAR_WRAP_BITS >= DATA_W) ? '1 :
        DATA_W'((64'd1 << TAR_WRAP_BITS) - 64'd1);

    logic [DATA_W-1:0] tar_q, tar_d;
    logic [DATA_W-1:0] incr;
    logic [DATA_W-1:0] sum;

    always_comb begin
        incr  = DATA_W'(1) << inc_size;
        sum   = tar_q + incr;
        tar_d = tar_q;
        if (wr_en) begin
            tar_d = wr_data;
        end else if (inc_en) begin
            tar_d = (tar_q & ~WRAP_MASK) | (sum & WRAP_MASK);
        end
    end

    always_ff @(posedge dclk) begin
        if (dbg_reset) begin
            tar_q <= '0;
        end else begin
            tar_q <= tar_d;
        end
    end

    assign tar_o = tar_q;

endmodule

// File: rtl/cm0_dbg_ap.sv
// Debug access port: CSW/TAR/DRW (and banked BD0-BD3 when CM0_DBG_AP_BD_EN is
// defined) bridging DP register accesses onto a single-outstanding SLV bus.
module cm0_dbg_ap
    import cm0_dbg_ap_pkg::*;
#(
    parameter int unsigned DBG           = 1,
    parameter int unsigned TAR_WRAP_BITS = 10
) (
    input  logic              dclk,
    input  logic              dbg_reset,
    input  logic              ap_req_i,
    input  logic              ap_write_i,
    input  logic [2:0]        ap_addr_i,
    input  logic [DATA_W-1:0] ap_wdata_i,
    output logic              ap_ack_o,
    output logic [DATA_W-1:0] ap_rdata_o,
    output logic              ap_err_o,
    output logic [1:0]        slv_trans_o,
    output logic [DATA_W-1:0] slv_addr_o,
    output logic [1:0]        slv_size_o,
    output logic              slv_write_o,
    output logic [DATA_W-1:0] slv_wdata_o,
    input  logic [DATA_W-1:0] slv_rdata_i,
    input  logic              slv_ready_i,
    input  logic              slv_resp_i
);

`ifdef CM0_DBG_AP_BD_EN
    localparam bit BD_EN = 1'b1;
`else
    localparam bit BD_EN = 1'b0;
`endif

    if (DBG != 0) begin : g_core
        state_e            state_q, state_d;
        logic              ack_q, ack_d;
        logic              err_q, err_d;
        logic [DATA_W-1:0] rdata_q, rdata_d;
        logic [1:0]        trans_q, trans_d;
        logic [DATA_W-1:0] addr_q, addr_d;
        logic [1:0]        size_q, size_d;
        logic              write_q, write_d;
        logic [DATA_W-1:0] wdata_q, wdata_d;
        logic [DATA_W-1:0] hold_q, hold_d;
        logic              is_bd_q, is_bd_d;
        logic [1:0]        csw_size_q, csw_size_d;
        logic [1:0]        csw_inc_q, csw_inc_d;
        logic              csw_err_q, csw_err_d;
        logic              tar_wr, tar_inc;
        logic [DATA_W-1:0] tar;
        logic [DATA_W-1:0] csw_rd;
        logic              sel_bd, sel_xfer;

        cm0_dbg_ap_tar #(.TAR_WRAP_BITS(TAR_WRAP_BITS)) u_tar (
            .dclk      (dclk),
            .dbg_reset (dbg_reset),
            .wr_en     (tar_wr),
            .wr_data   (ap_wdata_i),
            .inc_en    (tar_inc),
            .inc_size  (csw_size_q),
            .tar_o     (tar)
        );

        always_comb begin
            csw_rd = '0;
            csw_rd[CSW_SIZE_LSB +: 2] = csw_size_q;
            csw_rd[CSW_INC_LSB +: 2]  = csw_inc_q;
            csw_rd[CSW_ERR_BIT]       = csw_err_q;
            csw_rd[CSW_BUSY_BIT]      = (state_q != ST_IDLE);
        end

        assign sel_bd   = BD_EN && ap_addr_i[2];
        assign sel_xfer = (ap_addr_i == REG_DRW) || sel_bd;

        // Next-state and registered-output logic for the transfer FSM.
        always_comb begin
            state_d    = state_q;
            ack_d      = 1'b0;
            err_d      = 1'b0;
            rdata_d    = '0;
            trans_d    = HTRANS_IDLE;
            addr_d     = addr_q;
            size_d     = size_q;
            write_d    = write_q;
            wdata_d    = '0;
            hold_d     = hold_q;
            is_bd_d    = is_bd_q;
            csw_size_d = csw_size_q;
            csw_inc_d  = csw_inc_q;
            csw_err_d  = csw_err_q;
            tar_wr     = 1'b0;
            tar_inc    = 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    // ack_q blocks re-accepting a request still held during its own ack.
                    if (ap_req_i && !ack_q) begin
                        ack_d = 1'b1;
                        if (sel_xfer) begin
                            if (csw_size_q == SIZE_RSV) begin
                                err_d     = 1'b1;
                                csw_err_d = 1'b1;
                            end else begin
                                ack_d   = 1'b0;
                                state_d = ST_ADDR;
                                trans_d = HTRANS_NONSEQ;
                                addr_d  = sel_bd ? {tar[DATA_W-1:4], ap_addr_i[1:0], 2'b00} : tar;
                                size_d  = sel_bd ? SIZE_WORD : csw_size_q;
                                write_d = ap_write_i;
                                hold_d  = ap_wdata_i;
                                is_bd_d = sel_bd;
                            end
                        end else begin
                            case (ap_addr_i)
                                REG_CSW: begin
                                    if (ap_write_i) begin
                                        csw_size_d = ap_wdata_i[CSW_SIZE_LSB +: 2];
                                        csw_inc_d  = ap_wdata_i[CSW_INC_LSB +: 2];
                                        if (ap_wdata_i[CSW_ERR_BIT]) begin
                                            csw_err_d = 1'b0;
                                        end
                                    end else begin
                                        rdata_d = csw_rd;
                                    end
                                end
                                REG_TAR: begin
                                    if (ap_write_i) begin
                                        tar_wr = 1'b1;
                                    end else begin
                                        rdata_d = tar;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (slv_ready_i) begin
                        state_d = ST_DATA;
                        wdata_d = write_q ? hold_q : '0;
                    end else begin
                        trans_d = HTRANS_NONSEQ;
                    end
                end
                ST_DATA: begin
                    wdata_d = wdata_q;
                    if (slv_ready_i) begin
                        state_d = ST_RESP;
                        wdata_d = '0;
                        ack_d   = 1'b1;
                        err_d   = slv_resp_i;
                        rdata_d = write_q ? '0 : slv_rdata_i;
                        if (slv_resp_i) begin
                            csw_err_d = 1'b1;
                        end else if (!is_bd_q && csw_inc_q == INC_SINGLE) begin
                            tar_inc = 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge dclk) begin
            if (dbg_reset) begin
                state_q    <= ST_IDLE;
                ack_q      <= 1'b0;
                err_q      <= 1'b0;
                rdata_q    <= '0;
                trans_q    <= HTRANS_IDLE;
                addr_q     <= '0;
                size_q     <= '0;
                write_q    <= 1'b0;
                wdata_q    <= '0;
                hold_q     <= '0;
                is_bd_q    <= 1'b0;
                csw_size_q <= CSW_RESET[CSW_SIZE_LSB +: 2];
                csw_inc_q  <= CSW_RESET[CSW_INC_LSB +: 2];
                csw_err_q  <= CSW_RESET[CSW_ERR_BIT];
            end else begin
                state_q    <= state_d;
                ack_q      <= ack_d;
                err_q      <= err_d;
                rdata_q    <= rdata_d;
                trans_q    <= trans_d;
                addr_q     <= addr_d;
                size_q     <= size_d;
                write_q    <= write_d;
                wdata_q    <= wdata_d;
                hold_q     <= hold_d;
                is_bd_q    <= is_bd_d;
                csw_size_q <= csw_size_d;
                csw_inc_q  <= csw_inc_d;
                csw_err_q  <= csw_err_d;
            end
        end

        assign ap_ack_o    = ack_q;
        assign ap_err_o    = err_q;
        assign ap_rdata_o  = rdata_q;
        assign slv_trans_o = trans_q;
        assign slv_addr_o  = addr_q;
        assign slv_size_o  = size_q;
        assign slv_write_o = write_q;
        assign slv_wdata_o = wdata_q;
    end else begin : g_stub
        // Block absent: acknowledge every request after one cycle, drive nothing else.
        logic ack_q, ack_d;

        assign ack_d = ap_req_i && !ack_q;

        always_ff @(posedge dclk) begin
            if (dbg_reset) begin
                ack_q <= 1'b0;
            end else begin
                ack_q <= ack_d;
            end
        end

        assign ap_ack_o    = ack_q;
        assign ap_err_o    = 1'b0;
        assign ap_rdata_o  = '0;
        assign slv_trans_o = HTRANS_IDLE;
        assign slv_addr_o  = '0;
        assign slv_size_o  = '0;
        assign slv_write_o = 1'b0;
        assign slv_wdata_o = '0;
    end

endmodule

// File: tb/tb_cm0_dbg_ap.sv
// Directed self-checking bench for cm0_dbg_ap; BD checks follow CM0_DBG_AP_BD_EN.
module tb_cm0_dbg_ap;

    logic        dclk = 1'b0;
    logic        dbg_reset;
    logic        ap_req_i;
    logic        ap_write_i;
    logic [2:0]  ap_addr_i;
    logic [31:0] ap_wdata_i;
    logic        ap_ack_o;
    logic [31:0] ap_rdata_o;
    logic        ap_err_o;
    logic [1:0]  slv_trans_o;
    logic [31:0] slv_addr_o;
    logic [1:0]  slv_size_o;
    logic        slv_write_o;
    logic [31:0] slv_wdata_o;
    logic [31:0] slv_rdata_i;
    logic        slv_ready_i;
    logic        slv_resp_i;

    int tests = 0;
    int fails = 0;

    // Results of the most recent access
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_err, r_write, r_stable;
    int          r_lat, r_nonseq;

    cm0_dbg_ap dut (
        .dclk        (dclk),
        .dbg_reset   (dbg_reset),
        .ap_req_i    (ap_req_i),
        .ap_write_i  (ap_write_i),
        .ap_addr_i   (ap_addr_i),
        .ap_wdata_i  (ap_wdata_i),
        .ap_ack_o    (ap_ack_o),
        .ap_rdata_o  (ap_rdata_o),
        .ap_err_o    (ap_err_o),
        .slv_trans_o (slv_trans_o),
        .slv_addr_o  (slv_addr_o),
        .slv_size_o  (slv_size_o),
        .slv_write_o (slv_write_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_ready_i (slv_ready_i),
        .slv_resp_i  (slv_resp_i)
    );

    always #5 dclk = ~dclk;

    // One AP access acting as DP and SLV slave; aw/dw are wait cycles in ADDR/DATA.
    task automatic xfer(input bit wr, input logic [2:0] a, input logic [31:0] wd,
                        input int aw, input int dw, input bit resp, input logic [31:0] srd);
        int  acnt = 0;
        int  dcnt = 0;
        bit  in_data = 1'b0;
        bit  done = 1'b0;
        r_nonseq = 0; r_stable = 1'b1; r_wdata = '0; r_lat = 0; r_err = 1'b0;
        r_rdata = '0; r_addr = '0; r_size = '0; r_write = 1'b0;
        @(negedge dclk);
        ap_req_i = 1'b1; ap_write_i = wr; ap_addr_i = a; ap_wdata_i = wd;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge dclk);
            slv_ready_i = 1'b0; slv_resp_i = 1'b0; slv_rdata_i = '0;
            if (ap_ack_o) begin
                done = 1'b1; r_lat = cyc; r_rdata = ap_rdata_o; r_err = ap_err_o;
                ap_req_i = 1'b0;
            end else if (slv_trans_o == 2'b10) begin
                if (r_nonseq == 0) begin
                    r_addr = slv_addr_o; r_size = slv_size_o; r_write = slv_write_o;
                end else if (slv_addr_o !== r_addr || slv_size_o !== r_size) begin
                    r_stable = 1'b0;
                end
                r_nonseq++;
                slv_ready_i = (acnt >= aw);
                in_data = slv_ready_i;
                acnt++;
            end else if (in_data) begin
                if (dcnt == 0) r_wdata = slv_wdata_o;
                slv_ready_i = (dcnt >= dw); slv_resp_i = resp; slv_rdata_i = srd;
                dcnt++;
            end
        end
        ap_req_i = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        xfer(1'b1, a, d, 0, 0, 1'b0, 32'h0);
    endtask

    task automatic reg_rd(input logic [2:0] a);
        xfer(1'b0, a, 32'h0, 0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        dbg_reset = 1'b1;
        repeat (3) @(negedge dclk);
        tests++; if ({slv_trans_o, ap_ack_o, ap_err_o} !== 4'b0 || slv_addr_o !== 0 || ap_rdata_o !== 0 || slv_wdata_o !== 0) begin
            fails++; $display("FAIL reset_outputs got trans=%b ack=%b err=%b addr=%h exp all 0", slv_trans_o, ap_ack_o, ap_err_o, slv_addr_o); end
        dbg_reset = 1'b0;
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h2 || r_lat !== 1 || r_nonseq !== 0) begin
            fails++; $display("FAIL reset_csw got %h lat %0d ns %0d exp 00000002 lat 1 ns 0", r_rdata, r_lat, r_nonseq); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h0 || r_lat !== 1 || r_nonseq !== 0) begin
            fails++; $display("FAIL reset_tar got %h lat %0d ns %0d exp 0 lat 1 ns 0", r_rdata, r_lat, r_nonseq); end
    endtask

    task automatic test_drw_write();
        reg_wr(3'd1, 32'h2000_0000);
        xfer(1'b1, 3'd3, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
        tests++; if (r_nonseq !== 1 || r_addr !== 32'h2000_0000 || r_write !== 1'b1 || r_size !== 2'd2) begin
            fails++; $display("FAIL drw_wr_addr got ns %0d addr %h wr %b size %0d exp 1 20000000 1 2", r_nonseq, r_addr, r_write, r_size); end
        tests++; if (r_wdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL drw_wr_wdata got %h exp deadbeef", r_wdata); end
        tests++; if (r_lat !== 3 || r_err !== 1'b0) begin
            fails++; $display("FAIL drw_wr_lat got lat %0d err %b exp 3 0", r_lat, r_err); end
    endtask

    task automatic test_inc_wrap();
        reg_wr(3'd0, 32'h12);
        reg_wr(3'd1, 32'h2000_03FC);
        xfer(1'b0, 3'd3, 32'h0, 0, 0, 1'b0, 32'h1111_1111);
        tests++; if (r_addr !== 32'h2000_03FC || r_rdata !== 32'h1111_1111) begin
            fails++; $display("FAIL inc_rd1 got addr %h data %h exp 200003fc 11111111", r_addr, r_rdata); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h2000_0000) begin
            fails++; $display("FAIL inc_wrap_tar got %h exp 20000000", r_rdata); end
        xfer(1'b0, 3'd3, 32'h0, 0, 0, 1'b0, 32'h2222_2222);
        tests++; if (r_addr !== 32'h2000_0000 || r_rdata !== 32'h2222_2222) begin
            fails++; $display("FAIL inc_rd2 got addr %h data %h exp 20000000 22222222", r_addr, r_rdata); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h2000_0004) begin
            fails++; $display("FAIL inc_tar2 got %h exp 20000004", r_rdata); end
    endtask

    task automatic test_wait_err();
        reg_wr(3'd0, 32'h12);
        reg_wr(3'd1, 32'h0000_0100);
        xfer(1'b0, 3'd3, 32'h0, 2, 3, 1'b1, 32'h5555_5555);
        tests++; if (r_nonseq !== 3 || r_stable !== 1'b1 || r_addr !== 32'h100) begin
            fails++; $display("FAIL wait_addr got ns %0d stable %b addr %h exp 3 1 00000100", r_nonseq, r_stable, r_addr); end
        tests++; if (r_lat !== 8 || r_err !== 1'b1) begin
            fails++; $display("FAIL wait_err_ack got lat %0d err %b exp 8 1", r_lat, r_err); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h100) begin
            fails++; $display("FAIL err_tar_hold got %h exp 00000100", r_rdata); end
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h52) begin
            fails++; $display("FAIL err_sticky got %h exp 00000052", r_rdata); end
        reg_wr(3'd0, 32'h52);
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h12) begin
            fails++; $display("FAIL err_clear got %h exp 00000012", r_rdata); end
    endtask

    task automatic test_sizes();
        reg_wr(3'd0, 32'h10);
        reg_wr(3'd1, 32'h0000_03FF);
        reg_rd(3'd3);
        tests++; if (r_size !== 2'd0) begin
            fails++; $display("FAIL byte_size got %0d exp 0", r_size); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h0) begin
            fails++; $display("FAIL byte_wrap got %h exp 0", r_rdata); end
        reg_wr(3'd0, 32'h11);
        reg_wr(3'd1, 32'h2000_0002);
        reg_rd(3'd3);
        reg_rd(3'd1);
        tests++; if (r_size !== 2'd0 || r_rdata !== 32'h2000_0004) begin
            fails++; $display("FAIL half_inc got %h exp 20000004", r_rdata); end
        reg_wr(3'd0, 32'h22);
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h22) begin
            fails++; $display("FAIL csw_rsv_inc got %h exp 00000022", r_rdata); end
        reg_wr(3'd1, 32'h8);
        reg_rd(3'd3);
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h8) begin
            fails++; $display("FAIL rsv_inc_off got %h exp 00000008", r_rdata); end
    endtask

    task automatic test_reserved();
        reg_wr(3'd2, 32'hFFFF_FFFF);
        tests++; if (r_lat !== 1 || r_nonseq !== 0) begin
            fails++; $display("FAIL rsv_wr got lat %0d ns %0d exp 1 0", r_lat, r_nonseq); end
        reg_rd(3'd2);
        tests++; if (r_rdata !== 32'h0 || r_lat !== 1) begin
            fails++; $display("FAIL rsv_rd got %h lat %0d exp 0 lat 1", r_rdata, r_lat); end
    endtask

    task automatic test_bd();
        reg_wr(3'd0, 32'h10);
        reg_wr(3'd1, 32'h4000_1238);
        xfer(1'b0, 3'd6, 32'h0, 0, 0, 1'b0, 32'hA5A5_0002);
`ifdef CM0_DBG_AP_BD_EN
        tests++; if (r_nonseq !== 1 || r_addr !== 32'h4000_1238 || r_size !== 2'd2 || r_rdata !== 32'hA5A5_0002 || r_lat !== 3) begin
            fails++; $display("FAIL bd2_rd got ns %0d addr %h size %0d data %h lat %0d exp 1 40001238 2 a5a50002 3", r_nonseq, r_addr, r_size, r_rdata, r_lat); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h4000_1238) begin
            fails++; $display("FAIL bd_tar_hold got %h exp 40001238", r_rdata); end
`else
        tests++; if (r_nonseq !== 0 || r_rdata !== 32'h0 || r_lat !== 1) begin
            fails++; $display("FAIL bd2_off got ns %0d data %h lat %0d exp 0 0 1", r_nonseq, r_rdata, r_lat); end
`endif
    endtask

    task automatic test_size3();
        reg_wr(3'd0, 32'h03);
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h03) begin
            fails++; $display("FAIL size3_csw got %h exp 00000003", r_rdata); end
        reg_rd(3'd3);
        tests++; if (r_lat !== 1 || r_err !== 1'b1 || r_nonseq !== 0) begin
            fails++; $display("FAIL size3_drw got lat %0d err %b ns %0d exp 1 1 0", r_lat, r_err, r_nonseq); end
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h43) begin
            fails++; $display("FAIL size3_err got %h exp 00000043", r_rdata); end
        reg_wr(3'd0, 32'h42);
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h02) begin
            fails++; $display("FAIL size3_restore got %h exp 00000002", r_rdata); end
    endtask

    task automatic test_reset_mid();
        bit acked = 1'b0;
        reg_wr(3'd0, 32'h12);
        reg_wr(3'd1, 32'h30);
        @(negedge dclk);
        ap_req_i = 1'b1; ap_write_i = 1'b1; ap_addr_i = 3'd3; ap_wdata_i = 32'h1234_5678;
        @(negedge dclk);
        tests++; if (slv_trans_o !== 2'b10) begin
            fails++; $display("FAIL mid_nonseq got %b exp 10", slv_trans_o); end
        slv_ready_i = 1'b1;
        @(negedge dclk);
        slv_ready_i = 1'b0;
        tests++; if (slv_wdata_o !== 32'h1234_5678 || slv_trans_o !== 2'b00) begin
            fails++; $display("FAIL mid_data got wdata %h trans %b exp 12345678 00", slv_wdata_o, slv_trans_o); end
        dbg_reset = 1'b1;
        @(negedge dclk);
        ap_req_i = 1'b0;
        dbg_reset = 1'b0;
        tests++; if (slv_trans_o !== 2'b00 || ap_ack_o !== 1'b0 || slv_wdata_o !== 0) begin
            fails++; $display("FAIL mid_reset_out got trans %b ack %b exp 00 0", slv_trans_o, ap_ack_o); end
        repeat (4) begin
            @(negedge dclk);
            if (ap_ack_o || slv_trans_o !== 2'b00) acked = 1'b1;
        end
        tests++; if (acked !== 1'b0) begin
            fails++; $display("FAIL mid_no_ack got activity %b exp 0", acked); end
        reg_rd(3'd0);
        tests++; if (r_rdata !== 32'h2) begin
            fails++; $display("FAIL mid_csw got %h exp 00000002", r_rdata); end
        reg_rd(3'd1);
        tests++; if (r_rdata !== 32'h0) begin
            fails++; $display("FAIL mid_tar got %h exp 0", r_rdata); end
    endtask

    initial begin
        dbg_reset = 1'b1; ap_req_i = 1'b0; ap_write_i = 1'b0; ap_addr_i = '0; ap_wdata_i = '0;
        slv_rdata_i = '0; slv_ready_i = 1'b0; slv_resp_i = 1'b0;
        test_reset();
        test_drw_write();
        test_inc_wrap();
        test_wait_err();
        test_sizes();
        test_reserved();
        test_bd();
        test_size3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
